dct_transpose_pp: RTL

Ping-pong 8×8 transpose buffer between the row pass and the column pass of the 2-D DCT. It accepts row-DCT coefficient rows (8 samples per beat) over a valid/ready handshake and stores each block of 8 rows. It then emits the same block column by column (8 samples per beat) to the column-pass DCT. Two banks let block N+1 be written while block N is read, so both sides sustain one beat per cycle.

---
 rtl/dct_transpose_pp.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dct_transpose_pp.sv
// Ping-pong 8x8 transpose buffer: rows are written into one bank while the
// other bank is read out column by column.
module dct_transpose_pp #(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in0,
    input  logic signed [DATA_W-1:0] in1,
    input  logic signed [DATA_W-1:0] in2,
    input  logic signed [DATA_W-1:0] in3,
    input  logic signed [DATA_W-1:0] in4,
    input  logic signed [DATA_W-1:0] in5,
    input  logic signed [DATA_W-1:0] in6,
    input  logic signed [DATA_W-1:0] in7,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out0,
    output logic signed [DATA_W-1:0] out1,
    output logic signed [DATA_W-1:0] out2,
    output logic signed [DATA_W-1:0] out3,
    output logic signed [DATA_W-1:0] out4,
    output logic signed [DATA_W-1:0] out5,
    output logic signed [DATA_W-1:0] out6,
    output logic signed [DATA_W-1:0] out7,
    output logic [2:0]               out_col,
    output logic                     out_last
);

    logic signed [DATA_W-1:0] mem [2][8][8];
    logic signed [DATA_W-1:0] in_lane  [8];
    logic signed [DATA_W-1:0] out_lane [8];

    logic [1:0] full;
    logic       wbank;
    logic       rbank;
    logic [2:0] wrow;
    logic [2:0] rcol;
    logic       in_acc;
    logic       out_acc;

    assign in_lane[0] = in0;
    assign in_lane[1] = in1;
    assign in_lane[2] = in2;
    assign in_lane[3] = in3;
    assign in_lane[4] = in4;
    assign in_lane[5] = in5;
    assign in_lane[6] = in6;
    assign in_lane[7] = in7;

    assign in_ready  = !full[wbank];
    assign out_valid = full[rbank];
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;
    assign out_col   = rcol;
    assign out_last  = out_valid && (rcol == 3'd7);

    // Sample storage carries no reset; the full flags decide what is meaningful.
    always_ff @(posedge clk) begin
        if (in_acc) begin
            for (int c = 0; c < 8; c++) begin
                mem[wbank][wrow][c] <= in_lane[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank <= 1'b0;
            wrow  <= 3'd0;
        end else if (in_acc) begin
            wrow <= wrow + 3'd1;
            if (wrow == 3'd7) begin
                wbank <= !wbank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbank <= 1'b0;
            rcol  <= 3'd0;
        end else if (out_acc) begin
            rcol <= rcol + 3'd1;
            if (rcol == 3'd7) begin
                rbank <= !rbank;
            end
        end
    end

    // A write only completes on an empty bank and a read only on a full one,
    // so the two updates below can never target the same flag in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            if (in_acc && (wrow == 3'd7)) begin
                full[wbank] <= 1'b1;
            end
            if (out_acc && (rcol == 3'd7)) begin
                full[rbank] <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            out_lane[k] = '0;
            if (out_valid) begin
                out_lane[k] = mem[rbank][k][rcol];
            end
        end
    end

    assign out0 = out_lane[0];
    assign out1 = out_lane[1];
    assign out2 = out_lane[2];
    assign out3 = out_lane[3];
    assign out4 = out_lane[4];
    assign out5 = out_lane[5];
    assign out6 = out_lane[6];
    assign out7 = out_lane[7];

endmodule
